mine_count_engine: RTL and testbench
====================================

// Module: mine_count_engine
// PURPOSE
//  Consumes the 64-bit mine map produced by the mine generator and computes,
//  for every cell of the board, the number of mines among its 8 neighbours.
//  Scans one cell per clock. Produces a packed count map for the datapath
//  and a per-cell write stream that the gameboard renderer draws from.
//  Sits between mine generation and the datapath/gameboard stage.
// PARAMETERS
//  ROWS       8    board rows; cell index = row*COLS + col
//  COLS       8    board columns
//  CW         4    bits per cell count
//  MINE_CODE  4'hF value written for a cell that itself holds a mine
// PORTS
//  clk         in   1          system clock (CLOCK_50)
//  resetn      in   1          asynchronous, active-low reset
//  start       in   1          request scan; sampled only in IDLE
//  mine_map    in   ROWS*COLS  bit i = 1 -> mine in cell i
//  busy        out  1          high in SCAN and DONE
//  done        out  1          1-cycle pulse; count_map and mine_total valid
//  count_map   out  ROWS*COLS*CW  cell i count at [i*CW +: CW]
//  cell_wr     out  1          strobe: cell_idx/cell_cnt valid this cycle
//  cell_idx    out  $clog2(ROWS*COLS)    index of cell being written
//  cell_cnt    out  CW         count (or MINE_CODE) for cell_idx
//  mine_total  out  $clog2(ROWS*COLS+1)  number of mines in snapshot
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, cell_wr = 0;
//    cell_idx, cell_cnt, count_map, mine_total, scan index = 0.
//  - FSM: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: at an edge with start=1, capture mine_map into internal snapshot,
//    clear count_map and mine_total, set idx=0, go SCAN. start=0: hold.
//  - SCAN: each edge processes cell idx using the snapshot only:
//    cell_wr<=1, cell_idx<=idx, cell_cnt<=(snap[idx] ? MINE_CODE : n),
//    count_map[idx*CW +: CW]<=same value, mine_total += snap[idx], idx++.
//    n = popcount of existing neighbours (r+-1, c+-1), clipped at edges; no
//    wrap across rows or columns (cell 7 is not adjacent to cell 8). 0..8.
//  - Edge processing idx=N-1 (N=ROWS*COLS) moves to DONE.
//  - DONE (one cycle): done=1 coincident with cell_wr for idx N-1; count_map
//    and mine_total final. Next edge -> IDLE, cell_wr=0, done=0.
//  - Timing: start sampled at edge E0; cell_wr high cycles after E1..E64;
//    done high only in cycle after E64; busy high after E0 through DONE.
//  - cell_wr=0 in IDLE; cell_idx/cell_cnt hold last value.
//  - start while busy (SCAN or DONE): ignored, no restart, no extra pulse.
//  - mine_map changes after E0: no effect on the running scan.
//  - count_map holds its final value in IDLE until the next accepted start.
//  - Back-to-back: start high in the IDLE cycle after DONE is accepted.
//  - Reset mid-scan: all outputs cleared immediately; no done pulse; waits
//    in IDLE for a new start.
// TESTING
//  1 mine_map=0, start -> 64 cell_wr pulses idx 0..63, all counts 0,
//    done with idx 63, mine_total=0, busy low next cycle.
//  2 mine at idx 0 only -> cell0=F, cells 1,8,9=1, all others 0, total=1.
//  3 mine at idx 7 only -> cells 6,14,15=1; cell 8=0 (no wrap); total=1.
//  4 all mines except idx 27 -> cell27=8, all others=F, total=63;
//    mine at idx 27 only -> cells 18,19,20,26,28,34,35,36=1.
//  5 start pulsed and mine_map flipped to all-ones at cell 20 -> ignored,
//    results match original snapshot, exactly one done.
//  6 resetn low at cell 30 -> all outputs 0 async, no done; new start ->
//    complete correct scan.

Source files
------------

// File: rtl/mine_count_engine_if.sv
// rtl/mine_count_engine_if.sv - start/map request and count/cell-stream result bundle
interface mine_count_engine_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int CW   = 4
);
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int TW    = $clog2(N + 1);

   logic              start;
   logic [N-1:0]      mine_map;
   logic              busy;
   logic              done;
   logic [N*CW-1:0]   count_map;
   logic              cell_wr;
   logic [IDX_W-1:0]  cell_idx;
   logic [CW-1:0]     cell_cnt;
   logic [TW-1:0]     mine_total;

   modport master (
      output start, mine_map,
      input  busy, done, count_map, cell_wr, cell_idx, cell_cnt, mine_total
   );

   modport slave (
      input  start, mine_map,
      output busy, done, count_map, cell_wr, cell_idx, cell_cnt, mine_total
   );
endinterface

// File: rtl/mine_count_engine.sv
// rtl/mine_count_engine.sv - one-cell-per-clock neighbour mine counter
// Scans a snapshot of the mine map and emits per-cell counts plus a packed count map.
module mine_count_engine #(
   parameter int             ROWS      = 8,
   parameter int             COLS      = 8,
   parameter int             CW        = 4,
   parameter logic [CW-1:0]  MINE_CODE = 4'hF
) (
   input  logic                    clk,
   input  logic                    resetn,
   mine_count_engine_if.slave      bus
);
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int TW    = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_q;
   logic [N-1:0]      snap_q;
   logic [IDX_W-1:0]  idx_q;
   logic              busy_q;
   logic              done_q;
   logic              cell_wr_q;
   logic [IDX_W-1:0]  cell_idx_q;
   logic [CW-1:0]     cell_cnt_q;
   logic [N*CW-1:0]   count_map_q;
   logic [TW-1:0]     mine_total_q;

   logic [CW-1:0]     nbr_cnt;
   logic [CW-1:0]     cell_val_d;

   // Neighbours outside the board are skipped, so row ends never wrap.
   always_comb begin
      nbr_cnt = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int r;
            int c;
            r = int'(idx_q) / COLS + dr;
            c = int'(idx_q) % COLS + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
               nbr_cnt = nbr_cnt + CW'(snap_q[IDX_W'(r * COLS + c)]);
            end
         end
      end
      cell_val_d = snap_q[idx_q] ? MINE_CODE : nbr_cnt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         snap_q       <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cell_wr_q    <= 1'b0;
         cell_idx_q   <= '0;
         cell_cnt_q   <= '0;
         count_map_q  <= '0;
         mine_total_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cell_wr_q <= 1'b0;
               done_q    <= 1'b0;
               if (bus.start) begin
                  snap_q       <= bus.mine_map;
                  count_map_q  <= '0;
                  mine_total_q <= '0;
                  idx_q        <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= SCAN;
               end
            end
            SCAN: begin
               cell_wr_q                   <= 1'b1;
               cell_idx_q                  <= idx_q;
               cell_cnt_q                  <= cell_val_d;
               count_map_q[idx_q*CW +: CW] <= cell_val_d;
               mine_total_q                <= mine_total_q + TW'(snap_q[idx_q]);
               idx_q                       <= idx_q + 1'b1;
               if (idx_q == IDX_W'(N - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               cell_wr_q <= 1'b0;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.count_map  = count_map_q;
   assign bus.cell_wr    = cell_wr_q;
   assign bus.cell_idx   = cell_idx_q;
   assign bus.cell_cnt   = cell_cnt_q;
   assign bus.mine_total = mine_total_q;
endmodule

// File: tb/tb_mine_count_engine.sv
// tb/tb_mine_count_engine.sv - directed table-driven bench for mine_count_engine
module tb_mine_count_engine;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mine_count_engine_if bus ();
   mine_count_engine dut (.clk(clk), .resetn(resetn), .bus(bus));

   typedef struct {
      string       name;
      logic [63:0] map;
      int          idx;
      logic [3:0]  cnt;
   } vec_t;

   vec_t        vecs[$];
   int          errors = 0;
   int          checks = 0;
   logic [3:0]  got[64];
   int          wr_n, done_n, done_idx, done_tot;
   bit          order_ok;
   logic [255:0] done_map;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: explicit 8-offset neighbour walk.
   function automatic logic [3:0] model(input logic [63:0] m, input int i);
      int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      int n = 0;
      if (m[i]) return 4'hF;
      for (int k = 0; k < 8; k++) begin
         int r = i / 8 + dr[k];
         int c = i % 8 + dc[k];
         if (r >= 0 && r < 8 && c >= 0 && c < 8 && m[r*8+c]) n++;
      end
      return 4'(n);
   endfunction

   task automatic run_scan(input logic [63:0] map, input bit b2b, input bit poke);
      bit fin = 0;
      bit ok = 1;
      if (!b2b) @(negedge clk);
      bus.mine_map = map;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);
      check("no_wr_at_accept", bus.cell_wr, 0);
      wr_n = 0; done_n = 0; done_idx = -1; done_tot = -1; order_ok = 1; done_map = '0;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         if (bus.cell_wr) begin
            if (int'(bus.cell_idx) != wr_n) order_ok = 0;
            got[bus.cell_idx] = bus.cell_cnt;
            wr_n++;
         end
         if (bus.done) begin
            done_n++;
            done_idx = int'(bus.cell_idx);
            done_tot = int'(bus.mine_total);
            done_map = bus.count_map;
         end
         if (!bus.busy) fin = 1;
         else begin
            if (poke && bus.cell_wr && bus.cell_idx == 6'd20) begin
               bus.mine_map = '1;
               bus.start = 1'b1;
            end else bus.start = 1'b0;
            @(negedge clk);
         end
      end
      bus.start = 1'b0;
      check("scan_finished", fin, 1);
      check("wr_count", wr_n, 64);
      check("wr_order", order_ok, 1);
      check("done_pulses", done_n, 1);
      check("done_idx", done_idx, 63);
      check("done_total", done_tot, $countones(map));
      for (int i = 0; i < 64; i++)
         if (got[i] !== model(map, i) || done_map[i*4 +: 4] !== model(map, i)) ok = 0;
      check("cells_vs_model", ok, 1);
   endtask

   initial begin
      logic [63:0] last_map;
      bit          have_last = 0;
      int          hits;
      bit          found;

      vecs.push_back('{"zero_c0",  64'h0, 0, 4'h0});
      vecs.push_back('{"zero_c63", 64'h0, 63, 4'h0});
      vecs.push_back('{"m0_c0",    64'h1, 0, 4'hF});
      vecs.push_back('{"m0_c1",    64'h1, 1, 4'h1});
      vecs.push_back('{"m0_c8",    64'h1, 8, 4'h1});
      vecs.push_back('{"m0_c9",    64'h1, 9, 4'h1});
      vecs.push_back('{"m0_c2",    64'h1, 2, 4'h0});
      vecs.push_back('{"m7_c6",    64'h80, 6, 4'h1});
      vecs.push_back('{"m7_c14",   64'h80, 14, 4'h1});
      vecs.push_back('{"m7_c15",   64'h80, 15, 4'h1});
      vecs.push_back('{"m7_c8",    64'h80, 8, 4'h0});
      vecs.push_back('{"all_c27",  ~(64'h1 << 27), 27, 4'h8});
      vecs.push_back('{"all_c0",   ~(64'h1 << 27), 0, 4'hF});
      vecs.push_back('{"all_c63",  ~(64'h1 << 27), 63, 4'hF});
      vecs.push_back('{"m27_c18",  64'h1 << 27, 18, 4'h1});
      vecs.push_back('{"m27_c20",  64'h1 << 27, 20, 4'h1});
      vecs.push_back('{"m27_c26",  64'h1 << 27, 26, 4'h1});
      vecs.push_back('{"m27_c28",  64'h1 << 27, 28, 4'h1});
      vecs.push_back('{"m27_c34",  64'h1 << 27, 34, 4'h1});
      vecs.push_back('{"m27_c36",  64'h1 << 27, 36, 4'h1});
      vecs.push_back('{"m27_c37",  64'h1 << 27, 37, 4'h0});

      bus.start = 1'b0;
      bus.mine_map = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_cell_wr", bus.cell_wr, 0);
      check("rst_cell_idx", bus.cell_idx, 0);
      check("rst_cell_cnt", bus.cell_cnt, 0);
      check("rst_count_map", bus.count_map, 0);
      check("rst_total", bus.mine_total, 0);
      resetn = 1'b1;

      foreach (vecs[v]) begin
         if (!have_last || vecs[v].map !== last_map) begin
            run_scan(vecs[v].map, 0, 0);
            last_map = vecs[v].map;
            have_last = 1;
         end
         check({vecs[v].name, "_stream"}, got[vecs[v].idx], vecs[v].cnt);
         check({vecs[v].name, "_map"}, done_map[vecs[v].idx*4 +: 4], vecs[v].cnt);
      end

      repeat (3) @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_cell_wr", bus.cell_wr, 0);
      check("idle_map_hold", bus.count_map[27*4 +: 4], 4'hF);
      check("idle_total_hold", bus.mine_total, 1);

      run_scan(64'h80, 0, 0);
      run_scan(64'h1, 1, 0);
      check("b2b_c9", got[9], 4'h1);

      run_scan(64'h1 << 27, 0, 1);
      check("poke_c20", got[20], 4'h1);
      check("poke_c0", got[0], 4'h0);
      bus.mine_map = '0;
      hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy || bus.done) hits++;
      end
      check("poke_no_restart", hits, 0);

      @(negedge clk);
      bus.mine_map = 64'h1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      found = 0;
      for (int cyc = 0; cyc < 100 && !found; cyc++) begin
         if (bus.cell_wr && bus.cell_idx == 6'd30) found = 1;
         else @(negedge clk);
      end
      check("reach_cell30", found, 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_cell_wr", bus.cell_wr, 0);
      check("mid_rst_cell_idx", bus.cell_idx, 0);
      check("mid_rst_count_map", bus.count_map, 0);
      check("mid_rst_total", bus.mine_total, 0);
      @(negedge clk);
      resetn = 1'b1;
      hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy || bus.done || bus.cell_wr) hits++;
      end
      check("mid_rst_quiet", hits, 0);
      run_scan(64'h8000_0000_0000_0081, 0, 0);
      check("post_rst_c62", got[62], 4'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
